alu_exec_stage: RTL and testbench
=================================

// Module: alu_exec_stage
// PURPOSE
//  Execute-stage wrapper around the existing Alu (ports a,b,aluout,op,unsig,compout,overflow).
//  Accepts operation requests over valid/ready, registers the operands, evaluates them through one
//  Alu instance, and buffers results in a small FIFO for the downstream writeback stage.
//  Also keeps a saturating count of signed overflows.
// PARAMETERS
//  DEPTH  2  result FIFO entries; legal range 2..8
//  CNT_W  8  width of the overflow event counter
// PORTS
//  clk        in   1   single clock; all state changes on its rising edge
//  rst        in   1   asynchronous, active-high reset
//  in_valid   in   1   request present
//  in_ready   out  1   stage can accept; transfer = in_valid & in_ready
//  in_a       in   32  operand A
//  in_b       in   32  operand B
//  in_op      in   3   000 AND, 001 OR, 010 ADD, 100 NOR, 101 XOR, 110 SUB; 011 and 111 are illegal
//  in_unsig   in   1   1 = unsigned operation; passed to Alu.unsig
//  out_valid  out  1   FIFO head valid
//  out_ready  in   1   consumer accepts; pop = out_valid & out_ready
//  out_result out  32  Alu aluout (0 for an illegal op)
//  out_comp   out  1   Alu compout
//  out_ovf    out  1   Alu overflow (0 when unsig=1 or the op is illegal)
//  out_ill    out  1   1 = entry came from an illegal op
//  ovf_count  out  CNT_W  saturating count of pushed entries with out_ovf=1
//  cnt_clr    in   1   synchronous clear of ovf_count
//  trap       out  1   overflow trap flag (see CONFIGURATION)
//  trap_clr   in   1   synchronous clear of trap
// BEHAVIOUR
//  - Reset (async, rst=1): operand reg invalid, FIFO empty, ovf_count=0, trap=0.
//    in_ready=0 while rst=1 and 1 in the first cycle after release. out_valid=0.
//    out_result/out_comp/out_ovf/out_ill read 0.
//  - Reset mid-operation discards operand reg and all FIFO entries; no partial result emerges.
//  - Stage 1: on transfer, {a,b,op,unsig} are captured into the operand reg; opv=1.
//  - Stage 2: the Alu is combinational on the operand reg. When opv=1 and the FIFO can push,
//    the result is pushed and opv clears, unless a new transfer refills it in the same edge.
//  - FIFO can push when count<DEPTH, or count==DEPTH with a pop in the same cycle.
//    Same-cycle push and pop keeps count unchanged.
//  - in_ready = ~rst_hold & ~trap_stall & (~opv | fifo_can_push).
//    This gives full throughput of 1 op per cycle with out_ready held at 1.
//  - Latency: accept at edge N -> out_valid=1 after edge N+1 (FIFO empty case).
//  - Results leave in strict request order; FIFO head stays stable while out_valid & ~out_ready.
//  - Illegal op: push result=0, comp=0, ovf=0, ill=1; the operation never stalls.
//  - ovf_count increments by 1 on each push with ovf=1 and saturates at 2^CNT_W-1.
//    cnt_clr wins over a same-cycle increment (count becomes 0).
//  - Pointers wrap modulo DEPTH; count is DEPTH+1 states wide.
// CONFIGURATION
//  ALU_EXEC_OVF_TRAP_EN defined:
//    - A push with ovf=1 and unsig=0 sets trap on that edge.
//    - While trap=1: trap_stall=1 and in_ready=0. Entries already inside still drain.
//    - trap_clr clears trap; a same-cycle new trapping push wins (trap stays 1).
//  ALU_EXEC_OVF_TRAP_EN undefined:
//    - trap tied 0, trap_clr ignored, no stall; overflow is only reported per entry.
// TESTING
//  1 ADD a=32'h7FFFFFFF b=32'h7FFFFFFF unsig=0 -> out_result=32'hFFFFFFFE, out_ovf=1, ovf_count=1.
//  2 a=32'h43667107 b=32'h0CC64678, ops AND, ADD, SUB back-to-back with out_ready=1 ->
//    results 32'h00464000, 32'h502CB77F, 32'h36A02A8F in order, one per cycle, all ovf=0.
//  3 out_ready=0, issue 3 ADDs -> FIFO holds DEPTH=2, op reg holds the third, in_ready=0.
//    Then raise out_ready -> all 3 drain in order, no loss or duplication.
//  4 op=3'b011 -> out_ill=1, out_result=0, out_ovf=0; the next legal op is unaffected.
//  5 assert rst for 1 cycle with 2 entries queued -> out_valid=0, ovf_count=0, empty afterwards.
//  6 with ALU_EXEC_OVF_TRAP_EN: test 1 stimulus -> trap=1, in_ready=0 until trap_clr pulse;
//    ovf_count=255 + overflow -> stays 255; cnt_clr -> 0.

Source files
------------

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: operand register + ALU + result FIFO with overflow counter; optional trap via ALU_EXEC_OVF_TRAP_EN
module alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  input  logic        unsig,
  output logic [31:0] aluout,
  output logic        compout,
  output logic        overflow
);
  logic [31:0] w_sum;
  logic [31:0] w_dif;
  logic        w_ill;
  // result, signed-overflow and less-than compare; illegal ops yield all zeros
  always_comb begin
    w_sum    = a + b;
    w_dif    = a - b;
    w_ill    = op[1] & op[0];
    aluout   = op == 3'b000 ? a & b :
               op == 3'b001 ? a | b :
               op == 3'b010 ? w_sum :
               op == 3'b100 ? ~(a | b) :
               op == 3'b101 ? a ^ b :
               op == 3'b110 ? w_dif : 32'd0;
    overflow = ~unsig & (op == 3'b010 ? (a[31] == b[31]) & (w_sum[31] != a[31]) :
                         op == 3'b110 ? (a[31] != b[31]) & (w_dif[31] != a[31]) : 1'b0);
    compout  = ~w_ill & (unsig ? a < b : $signed(a) < $signed(b));
  end
endmodule

module alu_exec_stage #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [2:0]       in_op,
  input  logic             in_unsig,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_comp,
  output logic             out_ovf,
  output logic             out_ill,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             cnt_clr,
  output logic             trap,
  input  logic             trap_clr
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] OVF_MAX = {CNT_W{1'b1}};

  logic             r_opv;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [2:0]       r_op;
  logic             r_unsig;
  logic [34:0]      r_mem [DEPTH];
  logic [PW-1:0]    r_wp;
  logic [PW-1:0]    r_rp;
  logic [CW-1:0]    r_cnt;
  logic [CNT_W-1:0] r_ovf_cnt;
  logic [31:0]      w_res;
  logic             w_comp;
  logic             w_ovf;
  logic             w_ill;
  logic             w_pop;
  logic             w_can_push;
  logic             w_push;
  logic             w_acc;
  logic             w_trap_stall;
  logic [34:0]      w_head;

  alu u_alu (
    .a(r_a),
    .b(r_b),
    .op(r_op),
    .unsig(r_unsig),
    .aluout(w_res),
    .compout(w_comp),
    .overflow(w_ovf)
  );

  // handshake decode; a full FIFO still accepts a push when its head leaves this cycle
  always_comb begin
    w_ill      = r_op[1] & r_op[0];
    out_valid  = r_cnt != '0;
    w_pop      = out_valid & out_ready;
    w_can_push = (r_cnt < CNT_FULL) | w_pop;
    w_push     = r_opv & w_can_push;
    in_ready   = ~rst & ~w_trap_stall & (~r_opv | w_can_push);
    w_acc      = in_valid & in_ready;
    w_head     = out_valid ? r_mem[r_rp] : 35'd0;
    out_ill    = w_head[34];
    out_comp   = w_head[33];
    out_ovf    = w_head[32];
    out_result = w_head[31:0];
    ovf_count  = r_ovf_cnt;
  end

  // operand register: refilled by a transfer, emptied when its result is pushed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opv   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_unsig <= 1'b0;
    end else begin
      r_opv <= w_acc | (r_opv & ~w_push);
      if (w_acc) begin
        r_a     <= in_a;
        r_b     <= in_b;
        r_op    <= in_op;
        r_unsig <= in_unsig;
      end
    end
  end

  // FIFO storage needs no reset; the head is masked while empty
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= {w_ill, w_comp, w_ovf, w_res};
  end

  // FIFO pointers wrap at DEPTH; simultaneous push and pop leaves the count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= w_push ? (r_wp == PTR_LAST ? '0 : r_wp + 1'b1) : r_wp;
      r_rp  <= w_pop ? (r_rp == PTR_LAST ? '0 : r_rp + 1'b1) : r_rp;
      r_cnt <= (w_push & ~w_pop) ? r_cnt + 1'b1 : (w_pop & ~w_push) ? r_cnt - 1'b1 : r_cnt;
    end
  end

  // saturating overflow counter; clear beats a same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ovf_cnt <= '0;
    else r_ovf_cnt <= cnt_clr ? '0 : (w_push & w_ovf & r_ovf_cnt != OVF_MAX) ? r_ovf_cnt + 1'b1 : r_ovf_cnt;
  end

`ifdef ALU_EXEC_OVF_TRAP_EN
  logic r_trap;
  // trap latches on a signed-overflow push; a new trapping push beats trap_clr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_trap <= 1'b0;
    else r_trap <= (w_push & w_ovf & ~r_unsig) ? 1'b1 : trap_clr ? 1'b0 : r_trap;
  end
  assign trap         = r_trap;
  assign w_trap_stall = r_trap;
`else
  logic w_unused;
  assign w_unused     = trap_clr;
  assign trap         = 1'b0;
  assign w_trap_stall = 1'b0;
`endif
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: randomized and directed checks of alu_exec_stage against a queue-based model
module tb_alu_exec_stage;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;
  localparam int OVF_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_ready, in_unsig = 1'b0;
  logic [31:0] in_a = '0, in_b = '0;
  logic [2:0] in_op = '0;
  logic out_valid, out_ready = 1'b0, out_comp, out_ovf, out_ill;
  logic [31:0] out_result;
  logic [CNT_W-1:0] ovf_count;
  logic cnt_clr = 1'b0, trap, trap_clr = 1'b0;

  alu_exec_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_unsig(in_unsig),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_comp(out_comp), .out_ovf(out_ovf), .out_ill(out_ill),
    .ovf_count(ovf_count), .cnt_clr(cnt_clr), .trap(trap), .trap_clr(trap_clr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  logic        m_opv = 1'b0;
  logic [31:0] m_a, m_b;
  logic [2:0]  m_op;
  logic        m_us;
  logic [34:0] q[$];
  int          m_cnt = 0;
  logic        m_trap = 1'b0;
  logic [33:0] got[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // {ill, comp, ovf, result} from the operation's arithmetic meaning
  function automatic logic [34:0] ref_alu(input logic [31:0] a, b, input logic [2:0] op, input logic us);
    longint sa = $signed(a);
    longint sb = $signed(b);
    longint r = 0;
    logic [31:0] res = '0;
    logic ill = 1'b0;
    logic ovf;
    logic comp;
    case (op)
      3'd0: res = a & b;
      3'd1: res = a | b;
      3'd2: begin res = a + b; r = sa + sb; end
      3'd4: res = ~(a | b);
      3'd5: res = a ^ b;
      3'd6: begin res = a - b; r = sa - sb; end
      default: ill = 1'b1;
    endcase
    ovf = !us && (r > 64'sd2147483647 || r < -64'sd2147483648);
    comp = !ill && (us ? (a < b) : (sa < sb));
    return {ill, comp, ovf, res};
  endfunction

  task automatic cmp_out();
    logic [34:0] h;
    h = q.size() != 0 ? q[0] : 35'd0;
    chk("out_valid", out_valid, q.size() != 0);
    chk("out_result", out_result, h[31:0]);
    chk("out_ovf", out_ovf, h[32]);
    chk("out_comp", out_comp, h[33]);
    chk("out_ill", out_ill, h[34]);
    chk("ovf_count", ovf_count, m_cnt);
    chk("trap", trap, m_trap);
  endtask

  // one clock: drive inputs, check in_ready, advance model, check outputs at next negedge
  task automatic cyc(input logic iv, input logic [31:0] a, b, input logic [2:0] op, input logic us,
                     input logic ordy, input logic cc, input logic tc);
    logic pop, can, rdy, push, set;
    logic [34:0] e;
    in_valid = iv; in_a = a; in_b = b; in_op = op; in_unsig = us;
    out_ready = ordy; cnt_clr = cc; trap_clr = tc;
    #1;
    pop = q.size() > 0 && ordy;
    can = q.size() < DEPTH || (q.size() == DEPTH && pop);
    rdy = !m_trap && (!m_opv || can);
    push = m_opv && can;
    set = 1'b0;
    chk("in_ready", in_ready, rdy);
    if (out_valid && ordy) got.push_back({out_ill, out_ovf, out_result});
    if (pop) void'(q.pop_front());
    if (push) begin
      e = ref_alu(m_a, m_b, m_op, m_us);
      q.push_back(e);
      if (e[32] && m_cnt < OVF_MAX) m_cnt++;
      set = e[32];
    end
    if (cc) m_cnt = 0;
`ifdef ALU_EXEC_OVF_TRAP_EN
    m_trap = set ? 1'b1 : tc ? 1'b0 : m_trap;
`endif
    if (iv && rdy) begin
      m_opv = 1'b1; m_a = a; m_b = b; m_op = op; m_us = us;
    end else if (push) m_opv = 1'b0;
    @(negedge clk);
    cmp_out();
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, 32'd0, 32'd0, 3'd0, 1'b0, ordy, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_ovf_count", ovf_count, 0);
    q.delete(); m_opv = 1'b0; m_cnt = 0; m_trap = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);
    cmp_out();
  endtask

  initial begin
    logic [31:0] ra, rb;
    @(negedge clk);
    do_reset();
    // 1: signed overflow on ADD
    cyc(1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    chk("t1_result", out_result, 32'hFFFFFFFE);
    chk("t1_ovf", out_ovf, 1'b1);
    chk("t1_count", ovf_count, 1);
`ifdef ALU_EXEC_OVF_TRAP_EN
    chk("t6_trap", trap, 1'b1);
    chk("t6_stall", in_ready, 1'b0);
    cyc(1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6_trap_clr", trap, 1'b0);
`endif
    idle(1'b1);
    // 2: back-to-back AND, ADD, SUB
    got.delete();
    cyc(1'b1, 32'h43667107, 32'h0CC64678, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h43667107, 32'h0CC64678, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h43667107, 32'h0CC64678, 3'd6, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    chk("t2_count", got.size(), 3);
    chk("t2_and", got[0], 34'h000464000);
    chk("t2_add", got[1], 34'h0502CB77F);
    chk("t2_sub", got[2], 34'h036A02A8F);
    // 3: backpressure fills FIFO and operand register
    cyc(1'b1, 32'd1, 32'd10, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'd2, 32'd10, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'd3, 32'd10, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_stall", in_ready, 1'b0);
    chk("t3_head", out_result, 32'd11);
    got.delete();
    repeat (4) idle(1'b1);
    chk("t3_count", got.size(), 3);
    chk("t3_r0", got[0], 34'd11);
    chk("t3_r1", got[1], 34'd12);
    chk("t3_r2", got[2], 34'd13);
    // 4: illegal op then a legal one
    got.delete();
    cyc(1'b1, 32'd5, 32'd6, 3'b011, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'd5, 32'd6, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) idle(1'b1);
    chk("t4_ill", got[0], 34'h200000000);
    chk("t4_next", got[1], 34'd11);
    // 5: reset with queued entries
    cyc(1'b1, 32'h7FFFFFFF, 32'd1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h80000000, 32'd1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    chk("t5_pre_valid", out_valid, 1'b1);
    do_reset();
    chk("t5_valid", out_valid, 1'b0);
    chk("t5_count", ovf_count, 0);
    repeat (2) idle(1'b1);
    chk("t5_empty", out_valid, 1'b0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      ra = $urandom_range(0, 3) == 0 ? 32'h7FFFFFFF : $urandom_range(0, 3) == 0 ? 32'h80000000 : $urandom;
      rb = $urandom_range(0, 3) == 0 ? 32'h7FFFFFFF : $urandom_range(0, 3) == 0 ? 32'h80000000 : $urandom;
      cyc($urandom_range(0, 3) != 0, ra, rb, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0);
      if (i == 1500) do_reset();
    end
    // ovf_count saturation and clear
    for (int i = 0; i < 1500; i++)
      cyc(1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("sat_count", ovf_count, OVF_MAX);
    cyc(1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("clr_count", ovf_count, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
